// File: rtl/eight_bit_adder_pkg.sv
// Shared ALU definitions: datapath width and the registered result bundle
// used by the adder and other ALU units.
package eight_bit_adder_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] sum;
        logic                 c_out;
        logic                 overflow;
    } alu_result_t;

endpackage

// File: rtl/eight_bit_adder_full_adder.sv
// Single-bit full adder, one stage of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/eight_bit_adder.sv
// Registered ripple-carry adder with carry-out and signed-overflow flags;
// results appear one clock after the operands are sampled.
module eight_bit_adder
    import eight_bit_adder_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    alu_result_t      res_d;
    alu_result_t      res_q;

    assign c[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_comb begin
        res_d          = '0;
        res_d.sum      = s;
        res_d.c_out    = c[WIDTH];
        res_d.overflow = c[WIDTH] ^ c[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign sum      = res_q.sum;
    assign c_out    = res_q.c_out;
    assign overflow = res_q.overflow;

endmodule

// File: tb/tb_eight_bit_adder.sv
// Directed-vector bench for eight_bit_adder; outputs are compared as
// {sum, c_out, overflow} against hand-computed values.
module tb_eight_bit_adder;

    logic       clk;
    logic       rst;
    logic [7:0] x;
    logic [7:0] y;
    logic       c_in;
    logic [7:0] sum;
    logic       c_out;
    logic       overflow;

    int unsigned n_total;
    int unsigned n_bad;

    eight_bit_adder #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .y        (y),
        .c_in     (c_in),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got sum=%h c_out=%b ovf=%b, expected sum=%h c_out=%b ovf=%b",
                     tag, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [9:0] outs();
        return {sum, c_out, overflow};
    endfunction

    // Drive operands away from the edge, then sample just after the capturing edge.
    task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [7:0] es, input logic ec, input logic eo);
        @(negedge clk);
        x = a; y = b; c_in = ci;
        @(posedge clk);
        #1;
        check(tag, outs(), {es, ec, eo});
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst  = 1'b1;
        x    = 8'hFF;
        y    = 8'h01;
        c_in = 1'b0;

        #1;
        check("reset_async", outs(), {8'h00, 1'b0, 1'b0});
        @(posedge clk); #1;
        check("reset_hold1", outs(), {8'h00, 1'b0, 1'b0});
        @(posedge clk); #1;
        check("reset_hold2", outs(), {8'h00, 1'b0, 1'b0});

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("first_after_reset", outs(), {8'h00, 1'b1, 1'b0});

        op("add_01_04",   8'h01, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);
        op("add_00_00",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        op("neg_ovf_81_84", 8'h81, 8'h84, 1'b0, 8'h05, 1'b1, 1'b1);
        op("neg_ovf_81_85", 8'h81, 8'h85, 1'b0, 8'h06, 1'b1, 1'b1);
        op("pos_ovf_7F_41", 8'h7F, 8'h41, 1'b0, 8'hC0, 1'b0, 1'b1);
        op("mix_FF_81",   8'hFF, 8'h81, 1'b0, 8'h80, 1'b1, 1'b0);
        op("mix_85_05",   8'h85, 8'h05, 1'b0, 8'h8A, 1'b0, 1'b0);
        op("mix_05_85",   8'h05, 8'h85, 1'b0, 8'h8A, 1'b0, 1'b0);
        op("mix_FF_7E",   8'hFF, 8'h7E, 1'b0, 8'h7D, 1'b1, 1'b0);
        op("cin_FF_00",   8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        op("cin_7F_00",   8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

        // Inputs changing between edges must not disturb the held result.
        x = 8'h12; y = 8'h34; c_in = 1'b1;
        #2;
        check("hold_between_edges", outs(), {8'h80, 1'b0, 1'b1});

        // Mid-stream reset pulse between edges clears outputs immediately.
        @(negedge clk);
        x = 8'h01; y = 8'h04; c_in = 1'b0;
        rst = 1'b1;
        #1;
        check("midstream_reset", outs(), {8'h00, 1'b0, 1'b0});
        #1;
        rst = 1'b0;
        #1;
        check("after_pulse_pre_edge", outs(), {8'h00, 1'b0, 1'b0});
        @(posedge clk); #1;
        check("first_after_pulse", outs(), {8'h05, 1'b0, 1'b0});

        op("back_to_back_7F_41", 8'h7F, 8'h41, 1'b1, 8'hC1, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
